// File: rtl/processor_cu_pkg.sv
// Shared coprocessor definitions: default widths, FSM encoding and address selectors.
// Both the processor CU and the main CU import these so their encodings stay aligned.
package processor_cu_pkg;

    localparam int unsigned IDX_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQ_GRANT = 3'd1;
    localparam logic [STATE_W-1:0] ST_READ_A    = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_A    = 3'd3;
    localparam logic [STATE_W-1:0] ST_READ_B    = 3'd4;
    localparam logic [STATE_W-1:0] ST_WAIT_B    = 3'd5;
    localparam logic [STATE_W-1:0] ST_WRITE     = 3'd6;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd7;

    localparam logic [1:0] ADDR_SEL_A = 2'd0;
    localparam logic [1:0] ADDR_SEL_B = 2'd1;
    localparam logic [1:0] ADDR_SEL_C = 2'd2;

    // The bus is requested from REQ_GRANT through WRITE inclusive.
    function automatic logic holds_bus(input logic [STATE_W-1:0] st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/processor_cu_addr_gen.sv
// Row-major address generator for the A, B and C operands of one job.
// Offsets are formed at full precision, then added to the base modulo 2^ADDR_W.
module proc_addr_gen
    import processor_cu_pkg::*;
#(
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [1:0]        i_Sel,
    input  logic [IDX_W-1:0]  i_Row,
    input  logic [IDX_W-1:0]  i_Col,
    input  logic [IDX_W-1:0]  i_K_Index,
    input  logic [IDX_W-1:0]  i_K,
    input  logic [IDX_W-1:0]  i_N,
    input  logic [ADDR_W-1:0] i_A_Base,
    input  logic [ADDR_W-1:0] i_B_Base,
    input  logic [ADDR_W-1:0] i_C_Base,
    output logic [ADDR_W-1:0] o_Address
);

    // An IDX_W x IDX_W product plus an IDX_W index never exceeds 2*IDX_W+1 bits.
    localparam int unsigned OFF_W = 2 * IDX_W + 1;

    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] base;

    // Select operand base and row-major offset, then wrap into the address space.
    always_comb begin
        offset = '0;
        base   = '0;
        case (i_Sel)
            ADDR_SEL_A: begin
                offset = OFF_W'(i_Row) * OFF_W'(i_K) + OFF_W'(i_K_Index);
                base   = i_A_Base;
            end
            ADDR_SEL_B: begin
                offset = OFF_W'(i_K_Index) * OFF_W'(i_N) + OFF_W'(i_Col);
                base   = i_B_Base;
            end
            ADDR_SEL_C: begin
                offset = OFF_W'(i_Row) * OFF_W'(i_N) + OFF_W'(i_Col);
                base   = i_C_Base;
            end
            default: begin
                offset = '0;
                base   = '0;
            end
        endcase
        o_Address = base + ADDR_W'(offset);
    end

endmodule

// File: rtl/processor_cu.sv
// Processor control unit: accepts one (row, column) job from the main CU, computes
// the dot product of A's row and B's column over the shared memory bus, writes the
// element of C back and holds o_Result_Ready until the main CU acknowledges it.
module processor_cu
    import processor_cu_pkg::*;
#(
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Indexes_Ready,
    input  logic [IDX_W-1:0]  i_Row_Index,
    input  logic [IDX_W-1:0]  i_Column_Index,
    output logic              o_Indexes_Received,
    input  logic [IDX_W-1:0]  i_K,
    input  logic [IDX_W-1:0]  i_N,
    input  logic [ADDR_W-1:0] i_A_Base,
    input  logic [ADDR_W-1:0] i_B_Base,
    input  logic [ADDR_W-1:0] i_C_Base,
    output logic              o_Grant_Request,
    input  logic              i_Grant,
    output logic [ADDR_W-1:0] o_Mem_Address,
    output logic              o_Mem_Read,
    output logic              o_Mem_Write,
    output logic [DATA_W-1:0] o_Mem_Write_Data,
    input  logic [DATA_W-1:0] i_Mem_Read_Data,
    output logic              o_Result_Ready,
    input  logic              i_Result_Ack
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic               ack_q, ack_d;

    logic [IDX_W:0]     k_next;
    logic [DATA_W-1:0]  product;
    logic [1:0]         addr_sel;
    logic [ADDR_W-1:0]  gen_addr;
    logic               rd_en;
    logic               wr_en;

    proc_addr_gen #(
        .IDX_W (IDX_W),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .i_Sel    (addr_sel),
        .i_Row    (row_q),
        .i_Col    (col_q),
        .i_K_Index(k_q),
        .i_K      (i_K),
        .i_N      (i_N),
        .i_A_Base (i_A_Base),
        .i_B_Base (i_B_Base),
        .i_C_Base (i_C_Base),
        .o_Address(gen_addr)
    );

    // Next-state, operand latch and multiply-accumulate for one job.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        ack_d   = 1'b0;
        // Low DATA_W bits only: products and sums wrap as unsigned.
        product = a_q * i_Mem_Read_Data;
        k_next  = {1'b0, k_q} + (IDX_W + 1)'(1);

        case (state_q)
            ST_IDLE: begin
                if (i_Indexes_Ready) begin
                    row_d   = i_Row_Index;
                    col_d   = i_Column_Index;
                    k_d     = '0;
                    acc_d   = '0;
                    ack_d   = 1'b1;
                    state_d = ST_REQ_GRANT;
                end
            end
            ST_REQ_GRANT: begin
                if (i_Grant) begin
                    state_d = (i_K == '0) ? ST_WRITE : ST_READ_A;
                end
            end
            ST_READ_A: begin
                if (i_Grant) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_A: begin
                a_d     = i_Mem_Read_Data;
                state_d = ST_READ_B;
            end
            ST_READ_B: begin
                if (i_Grant) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                acc_d = acc_q + product;
                k_d   = k_next[IDX_W-1:0];
                // Extra index bit keeps the bound test correct when K is the maximum.
                if (k_next < {1'b0, i_K}) begin
                    state_d = ST_READ_A;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i_Grant) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_Result_Ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register job state; reset abandons any job in flight.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            ack_q   <= ack_d;
        end
    end

    // Pick which operand address the generator produces for the current state.
    always_comb begin
        addr_sel = ADDR_SEL_A;
        if (state_q == ST_READ_B) begin
            addr_sel = ADDR_SEL_B;
        end else if (state_q == ST_WRITE) begin
            addr_sel = ADDR_SEL_C;
        end
    end

    // Bus strobes are gated by i_Grant so a lost grant stalls with strobes low.
    always_comb begin
        rd_en              = i_Grant && ((state_q == ST_READ_A) || (state_q == ST_READ_B));
        wr_en              = i_Grant && (state_q == ST_WRITE);
        o_Mem_Read         = rd_en;
        o_Mem_Write        = wr_en;
        o_Mem_Address      = (rd_en || wr_en) ? gen_addr : '0;
        o_Mem_Write_Data   = wr_en ? acc_q : '0;
        o_Grant_Request    = holds_bus(state_q);
        o_Result_Ready     = (state_q == ST_DONE);
        o_Indexes_Received = ack_q;
    end

endmodule

// File: tb/tb_processor_cu.sv
// Self-checking bench for processor_cu: a word-addressed memory model with one-cycle
// read latency, directed scenarios plus randomized jobs, and expected C elements
// computed directly as dot products over the bench's own memory image.
module tb_processor_cu;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Indexes_Ready = 1'b0;
    logic [7:0]  i_Row_Index = '0;
    logic [7:0]  i_Column_Index = '0;
    logic        o_Indexes_Received;
    logic [7:0]  i_K = '0;
    logic [7:0]  i_N = '0;
    logic [15:0] i_A_Base = '0;
    logic [15:0] i_B_Base = '0;
    logic [15:0] i_C_Base = '0;
    logic        o_Grant_Request;
    logic        i_Grant = 1'b1;
    logic [15:0] o_Mem_Address;
    logic        o_Mem_Read;
    logic        o_Mem_Write;
    logic [31:0] o_Mem_Write_Data;
    logic [31:0] i_Mem_Read_Data = '0;
    logic        o_Result_Ready;
    logic        i_Result_Ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_count = 0;
    int wr_count = 0;
    int ack_count = 0;
    int viol = 0;
    int prev_ret = -1;
    logic [15:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [31:0] mem [0:65535];

    processor_cu #(
        .IDX_W (8),
        .ADDR_W(16),
        .DATA_W(32)
    ) dut (
        .i_Clock           (clk),
        .i_Reset           (i_Reset),
        .i_Indexes_Ready   (i_Indexes_Ready),
        .i_Row_Index       (i_Row_Index),
        .i_Column_Index    (i_Column_Index),
        .o_Indexes_Received(o_Indexes_Received),
        .i_K               (i_K),
        .i_N               (i_N),
        .i_A_Base          (i_A_Base),
        .i_B_Base          (i_B_Base),
        .i_C_Base          (i_C_Base),
        .o_Grant_Request   (o_Grant_Request),
        .i_Grant           (i_Grant),
        .o_Mem_Address     (o_Mem_Address),
        .o_Mem_Read        (o_Mem_Read),
        .o_Mem_Write       (o_Mem_Write),
        .o_Mem_Write_Data  (o_Mem_Write_Data),
        .i_Mem_Read_Data   (i_Mem_Read_Data),
        .o_Result_Ready    (o_Result_Ready),
        .i_Result_Ack      (i_Result_Ack)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Memory model and bus monitor: sample strobes mid-cycle, return read data one
    // cycle later, and garbage whenever no read was issued the cycle before.
    always begin
        @(negedge clk);
        rd_pend = o_Mem_Read;
        rd_addr = o_Mem_Address;
        if (o_Mem_Read) rd_count++;
        if (o_Mem_Write) begin
            wr_count++;
            last_wr_addr = o_Mem_Address;
            last_wr_data = o_Mem_Write_Data;
            mem[o_Mem_Address] = o_Mem_Write_Data;
        end
        if (o_Indexes_Received) ack_count++;
        if ((o_Mem_Read && o_Mem_Write) || ((o_Mem_Read || o_Mem_Write) && !i_Grant)) viol++;
        @(posedge clk);
        #1;
        i_Mem_Read_Data = rd_pend ? mem[rd_addr] : $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected element: plain dot product over the memory image, 32-bit wrap.
    function automatic logic [31:0] model(input int r, input int c, input int kk, input int nn,
                                          input logic [15:0] ab, input logic [15:0] bb);
        logic [31:0] s;
        logic [15:0] ia;
        logic [15:0] ib;
        s = '0;
        for (int k = 0; k < kk; k++) begin
            ia = 16'(int'(ab) + r * kk + k);
            ib = 16'(int'(bb) + k * nn + c);
            s  = s + mem[ia] * mem[ib];
        end
        return s;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"},   o_Indexes_Received, 0);
        chk({tag, "_greq"},  o_Grant_Request, 0);
        chk({tag, "_rd"},    o_Mem_Read, 0);
        chk({tag, "_wr"},    o_Mem_Write, 0);
        chk({tag, "_addr"},  o_Mem_Address, 0);
        chk({tag, "_wdata"}, o_Mem_Write_Data, 0);
        chk({tag, "_rdy"},   o_Result_Ready, 0);
    endtask

    task automatic offer_job(input int r, input int c, input int kk, input int nn,
                             input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] cb);
        @(posedge clk);
        #1;
        i_Row_Index     = 8'(r);
        i_Column_Index  = 8'(c);
        i_K             = 8'(kk);
        i_N             = 8'(nn);
        i_A_Base        = ab;
        i_B_Base        = bb;
        i_C_Base        = cb;
        i_Indexes_Ready = 1'b1;
    endtask

    // Wait for the accept pulse; returns its cycle or -1 on timeout.
    task automatic wait_ack(input string tag, output int t_ack);
        int guard;
        guard = 0;
        t_ack = -1;
        do begin
            @(negedge clk);
            guard++;
        end while (!o_Indexes_Received && guard < 20);
        chk({tag, "_ack_seen"}, o_Indexes_Received, 1);
        if (o_Indexes_Received) t_ack = cyc;
    endtask

    // One complete job: offer, optional 3-cycle grant loss in the first READ_B,
    // then check result value, address, latency, bus traffic and handshakes.
    task automatic run_job(input string tag, input int r, input int c, input int kk, input int nn,
                           input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] cb,
                           input bit stall, input bit hold);
        int t_ack, t_rdy, guard, wc0, rc0, ac0, exp_lat;
        logic [31:0] exp_val;
        logic [15:0] exp_addr;
        exp_val  = model(r, c, kk, nn, ab, bb);
        exp_addr = 16'(int'(cb) + r * nn + c);
        exp_lat  = 4 * kk + 2 + (stall ? 3 : 0);
        wc0 = wr_count;
        rc0 = rd_count;
        ac0 = ack_count;
        offer_job(r, c, kk, nn, ab, bb, cb);
        wait_ack(tag, t_ack);
        chk({tag, "_ack_after_return"}, (t_ack > prev_ret), 1);
        @(posedge clk);
        #1;
        if (!hold) i_Indexes_Ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_one_cycle"}, o_Indexes_Received, 0);
        if (stall) begin
            @(posedge clk);
            @(posedge clk);
            #1 i_Grant = 1'b0;
            repeat (3) @(posedge clk);
            #1 i_Grant = 1'b1;
        end
        guard = 0;
        while (!o_Result_Ready && guard < 4 * kk + 40) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready_seen"}, o_Result_Ready, 1);
        t_rdy = cyc;
        chk({tag, "_latency"}, 64'(t_rdy - t_ack), 64'(exp_lat));
        chk({tag, "_greq_done"}, o_Grant_Request, 0);
        chk({tag, "_writes"}, 64'(wr_count - wc0), 1);
        chk({tag, "_reads"}, 64'(rd_count - rc0), 64'(2 * kk));
        chk({tag, "_waddr"}, last_wr_addr, exp_addr);
        chk({tag, "_wdata"}, last_wr_data, exp_val);
        @(posedge clk);
        #1 i_Result_Ack = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_held"}, o_Result_Ready, 1);
        @(posedge clk);
        #1 i_Result_Ack = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_cleared"}, o_Result_Ready, 0);
        chk({tag, "_one_accept"}, 64'(ack_count - ac0), 1);
        prev_ret = cyc;
    endtask

    initial begin
        int t_ack, wc0, rdy_seen, kk, nn, r, c;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 i_Reset = 1'b0;
        @(negedge clk);
        chk_outputs_zero("reset");

        // Small worked example: 3*5 + 4*6 = 39 at C_Base+2.
        mem[16'h0102] = 32'd3;
        mem[16'h0103] = 32'd4;
        mem[16'h0200] = 32'd5;
        mem[16'h0202] = 32'd6;
        run_job("ex2x2", 1, 0, 2, 2, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0);
        chk("ex2x2_value", last_wr_data, 32'd39);
        chk("ex2x2_addr", last_wr_addr, 16'h0302);

        // K = 0: no reads, a single write of zero.
        run_job("k0", 3, 2, 0, 4, 16'h0400, 16'h0500, 16'h0600, 1'b0, 1'b0);
        chk("k0_value", last_wr_data, 32'd0);

        // Grant dropped for three cycles during the first READ_B.
        run_job("stall", 2, 1, 3, 3, 16'h0700, 16'h0800, 16'h0900, 1'b1, 1'b0);

        // All-ones operands wrap to 1.
        mem[16'h0A00] = 32'hFFFF_FFFF;
        mem[16'h0B00] = 32'hFFFF_FFFF;
        run_job("wrap", 0, 0, 1, 1, 16'h0A00, 16'h0B00, 16'h0C00, 1'b0, 1'b0);
        chk("wrap_value", last_wr_data, 32'h0000_0001);

        // Reset in WAIT_A: job abandoned, outputs cleared, nothing written.
        wc0 = wr_count;
        offer_job(1, 1, 2, 2, 16'h0D00, 16'h0E00, 16'h0F00);
        wait_ack("rst", t_ack);
        @(posedge clk);
        #1 i_Indexes_Ready = 1'b0;
        @(posedge clk);
        #1 i_Reset = 1'b1;
        @(posedge clk);
        #1 i_Reset = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        rdy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_Result_Ready || o_Grant_Request) rdy_seen++;
        end
        chk("midreset_quiet", rdy_seen, 0);
        chk("midreset_nowrite", 64'(wr_count - wc0), 0);
        prev_ret = cyc;
        run_job("after_rst", 1, 1, 2, 2, 16'h0D00, 16'h0E00, 16'h0F00, 1'b0, 1'b0);

        // Ready held high across DONE and ack: one accept per job, next job after IDLE.
        run_job("hold1", 2, 3, 3, 5, 16'h1000, 16'h1100, 16'h1200, 1'b0, 1'b1);
        run_job("hold2", 2, 3, 3, 5, 16'h1000, 16'h1100, 16'h1200, 1'b0, 1'b0);

        // Randomized jobs, including bases that wrap the address space.
        for (int j = 0; j < 8; j++) begin
            kk = int'($urandom_range(0, 6));
            nn = int'($urandom_range(1, 8));
            r  = int'($urandom_range(0, 7));
            c  = int'($urandom_range(0, nn - 1));
            run_job($sformatf("rand%0d", j), r, c, kk, nn,
                    16'($urandom), 16'($urandom), 16'($urandom),
                    (kk > 0) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        chk("bus_rules", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_cu.md
PROCESSOR_CU -- requirements
Module: processor_cu

Interface
REQ-001 SHALL have parameter IDX_W, default 8, width of row/column index and of K/N.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter DATA_W, default 32, memory data and accumulator width.
REQ-004 i_Clock  in  1  sole clock, all state on rising edge.
REQ-005 i_Reset  in  1  synchronous, active-high reset.
REQ-006 i_Indexes_Ready  in  1  main CU offers a job to this processor (level).
REQ-007 i_Row_Index  in  IDX_W  job row r, valid with i_Indexes_Ready.
REQ-008 i_Column_Index  in  IDX_W  job column c, valid with i_Indexes_Ready.
REQ-009 o_Indexes_Received  out  1  one-cycle pulse, job accepted.
REQ-010 i_K  in  IDX_W  inner dimension, stable for whole job.
REQ-011 i_N  in  IDX_W  row length of B and C, stable for whole job.
REQ-012 i_A_Base, i_B_Base, i_C_Base  in  ADDR_W each  matrix base addresses, stable for whole job.
REQ-013 o_Grant_Request  out  1  memory bus request to arbiter.
REQ-014 i_Grant  in  1  bus granted to this processor.
REQ-015 o_Mem_Address  out  ADDR_W  word address of current access.
REQ-016 o_Mem_Read  out  1  read strobe; data returns next cycle.
REQ-017 o_Mem_Write  out  1  write strobe.
REQ-018 o_Mem_Write_Data  out  DATA_W  write data.
REQ-019 i_Mem_Read_Data  in  DATA_W  read data, valid the cycle after o_Mem_Read.
REQ-020 o_Result_Ready  out  1  result element written to memory (level).
REQ-021 i_Result_Ack  in  1  main CU has consumed o_Result_Ready.

Function
REQ-022 Job computes C[r][c] = sum over k=0..K-1 of A[r][k]*B[k][c], row-major: A at A_Base+r*K+k, B at B_Base+k*N+c, C at C_Base+r*N+c; addresses modulo 2^ADDR_W.
REQ-023 Products and accumulation SHALL keep low DATA_W bits (wrap, unsigned); accumulator cleared at job accept.
REQ-024 States: IDLE, REQ_GRANT, READ_A, WAIT_A, READ_B, WAIT_B, WRITE, DONE.
REQ-025 IDLE: when i_Indexes_Ready=1, capture r,c, pulse o_Indexes_Received one cycle, set k=0, go REQ_GRANT; o_Indexes_Received never asserted outside this transition.
REQ-026 REQ_GRANT: o_Grant_Request=1 from here through WRITE inclusive; advance on i_Grant=1 to READ_A, or to WRITE if K=0 (result 0).
REQ-027 READ_A/READ_B: drive address and o_Mem_Read only while i_Grant=1; if i_Grant=0, hold state with strobes low (stall, no data loss).
REQ-028 WAIT_A: latch A operand; WAIT_B: accumulate A*B; then k+1, to READ_A if k+1<K else WRITE; 4 granted cycles per k.
REQ-029 WRITE: when i_Grant=1, o_Mem_Write=1 one cycle with C address and accumulator, then DONE; stall while i_Grant=0.
REQ-030 DONE: o_Result_Ready=1, o_Grant_Request=0; on i_Result_Ack=1 return IDLE; next job accepted no earlier than cycle after return.
REQ-031 i_Indexes_Ready while not IDLE SHALL be ignored; i_Result_Ack outside DONE ignored.
REQ-032 o_Mem_Read and o_Mem_Write SHALL never be high together nor while i_Grant=0.

Reset
REQ-033 i_Reset=1 at any edge, including mid-job, SHALL force IDLE, clear accumulator/k/r/c, drive all outputs 0 next cycle; aborted job produces no write and no o_Result_Ready.

Structure
REQ-034 State encoding localparams and IDX_W/ADDR_W/DATA_W defaults SHALL live in a shared coprocessor package used with main_cu.
REQ-035 Address generation (r*K+k, k*N+c, r*N+c) SHALL be one sub-module, proc_addr_gen; multiply-accumulate stays inline.

Verification
REQ-036 K=2,N=2,r=1,c=0, A row1={3,4}, B col0={5,6}, grant always 1 -> one-cycle ack, C[1][0]=39 written at C_Base+2, o_Result_Ready 10 cycles after ack.
REQ-037 K=0 -> no reads, single write of 0, o_Result_Ready follows.
REQ-038 i_Grant dropped 3 cycles during READ_B -> strobes low, state held, final result unchanged, latency +3.
REQ-039 A=B=32'hFFFF_FFFF, K=1 -> result 32'h0000_0001 (wrap).
REQ-040 i_Reset pulsed in WAIT_A -> no write, all outputs 0; next job computes correctly.
REQ-041 i_Indexes_Ready held high through DONE and ack -> exactly one ack per job, second job starts only after return to IDLE.
